// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared state encoding, symbol defaults and width helper for the PHY receive path
package phy_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_HUNT   = 2'd0;
  localparam state_t ST_COUNT  = 2'd1;
  localparam state_t ST_LOCKED = 2'd2;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
  localparam logic [7:0] IDLE_DEFAULT  = 8'h7C;

  // Counter width for a parameter value: $clog2, but never narrower than one bit
  function automatic int cnt_w(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/phy_rx_lane_aligner_if.sv
// rtl/phy_rx_lane_aligner_if.sv - serial input and lane outputs of the receive aligner
interface phy_rx_lane_aligner_if #(
  parameter int DATA_W  = 8,
  parameter int N_LANES = 4
);

  logic                        serial_in;
  logic [N_LANES*DATA_W-1:0]   data_out;
  logic [N_LANES-1:0]          valid_out;
  logic                        word_stb;
  logic                        active;

  modport master (
    input  serial_in,
    output data_out, valid_out, word_stb, active
  );

  modport slave (
    output serial_in,
    input  data_out, valid_out, word_stb, active
  );

endinterface

// File: rtl/phy_comma_sync.sv
// rtl/phy_comma_sync.sv - comma hunt, word framing and lock / loss-of-sync state machine
module phy_comma_sync
  import phy_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                SYNC_COUNT = 4,
  parameter int                MAX_GAP    = 64,
  parameter logic [DATA_W-1:0] COMMA      = COMMA_DEFAULT
) (
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] word,
  output logic              word_boundary,
  output logic              locked,
  output logic              gap_expired
);

  localparam int BW = cnt_w(DATA_W);
  localparam int CW = cnt_w(SYNC_COUNT);
  localparam int GW = cnt_w(MAX_GAP);

  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
  localparam logic [CW-1:0] COMMA_LAST = CW'(SYNC_COUNT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(MAX_GAP - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]     comma_cnt_q, comma_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              is_comma;

  // Shift in the next bit, frame words and run the hunt/count/locked transitions
  always_comb begin
    sr_d          = {sr_q[DATA_W-2:0], serial_in};
    word          = sr_d;
    is_comma      = (sr_d == COMMA);
    word_boundary = (state_q != ST_HUNT) && (bit_cnt_q == BIT_LAST);
    locked        = (state_q == ST_LOCKED);
    gap_expired   = (MAX_GAP != 0) && locked && word_boundary && !is_comma
                    && (gap_cnt_q == GAP_LAST);

    state_d     = state_q;
    bit_cnt_d   = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BW'(1);
    comma_cnt_d = comma_cnt_q;
    gap_cnt_d   = gap_cnt_q;

    case (state_q)
      ST_HUNT: begin
        bit_cnt_d = '0;
        gap_cnt_d = '0;
        if (is_comma) begin
          comma_cnt_d = CW'(1);
          state_d     = (SYNC_COUNT == 1) ? ST_LOCKED : ST_COUNT;
        end
      end
      ST_COUNT: begin
        gap_cnt_d = '0;
        if (word_boundary) begin
          if (!is_comma) begin
            state_d     = ST_HUNT;
            comma_cnt_d = '0;
          end else if (comma_cnt_q == COMMA_LAST) begin
            state_d = ST_LOCKED;
          end else begin
            comma_cnt_d = comma_cnt_q + CW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (word_boundary) begin
          // A comma always wins, even on the boundary where the gap would expire
          if (is_comma) begin
            gap_cnt_d = '0;
          end else if (gap_expired) begin
            state_d     = ST_HUNT;
            gap_cnt_d   = '0;
            comma_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= ST_HUNT;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

endmodule

// File: rtl/phy_rx_lane_aligner.sv
// rtl/phy_rx_lane_aligner.sv - receive aligner top: round-robin lane demux and registered lane outputs
module phy_rx_lane_aligner
  import phy_pkg::*;
#(
  parameter int                DATA_W     = 8,
  parameter int                N_LANES    = 4,
  parameter logic [DATA_W-1:0] COMMA      = COMMA_DEFAULT,
  parameter logic [DATA_W-1:0] IDLE       = IDLE_DEFAULT,
  parameter int                SYNC_COUNT = 4,
  parameter int                MAX_GAP    = 64
) (
  input  logic                  clk_32f,
  input  logic                  reset,
  phy_rx_lane_aligner_if.master rx
);

  localparam int            LW       = cnt_w(N_LANES);
  localparam logic [LW-1:0] LANE_LAST = LW'(N_LANES - 1);

  logic [DATA_W-1:0]         word;
  logic                      word_boundary;
  logic                      locked;
  logic                      gap_expired;

  logic [N_LANES*DATA_W-1:0] data_q, data_d;
  logic [N_LANES-1:0]        valid_q, valid_d;
  logic [LW-1:0]             lane_ptr_q, lane_ptr_d;
  logic                      word_stb_q, word_stb_d;

  phy_comma_sync #(
    .DATA_W     (DATA_W),
    .SYNC_COUNT (SYNC_COUNT),
    .MAX_GAP    (MAX_GAP),
    .COMMA      (COMMA)
  ) u_sync (
    .clk_32f       (clk_32f),
    .reset         (reset),
    .serial_in     (rx.serial_in),
    .word          (word),
    .word_boundary (word_boundary),
    .locked        (locked),
    .gap_expired   (gap_expired)
  );

  // Steer each locked word to the current lane; commas realign, idles clear that lane's valid
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    lane_ptr_d = lane_ptr_q;
    word_stb_d = word_boundary && locked;

    if (!locked) begin
      lane_ptr_d = '0;
    end else if (word_boundary) begin
      if (word == COMMA) begin
        lane_ptr_d = '0;
      end else begin
        if (gap_expired) begin
          valid_d = '0;
        end else if (word == IDLE) begin
          valid_d[lane_ptr_q] = 1'b0;
        end else begin
          data_d[int'(lane_ptr_q)*DATA_W +: DATA_W] = word;
          valid_d[lane_ptr_q] = 1'b1;
        end
        lane_ptr_d = (lane_ptr_q == LANE_LAST) ? '0 : lane_ptr_q + LW'(1);
      end
    end
  end

  // Output and lane pointer registers with synchronous reset
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      data_q     <= '0;
      valid_q    <= '0;
      lane_ptr_q <= '0;
      word_stb_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      valid_q    <= valid_d;
      lane_ptr_q <= lane_ptr_d;
      word_stb_q <= word_stb_d;
    end
  end

  assign rx.data_out  = data_q;
  assign rx.valid_out = valid_q;
  assign rx.word_stb  = word_stb_q;
  assign rx.active    = locked;

endmodule
